// File: rtl/hex_scroll_pkg.sv
// Shared definitions for the HEX scroll controller: register map, field
// positions, segment constants and the message buffer type.
package hex_scroll_pkg;

    localparam logic [1:0] ADDR_CTRL   = 2'd0;
    localparam logic [1:0] ADDR_RATE   = 2'd1;
    localparam logic [1:0] ADDR_CHAR   = 2'd2;
    localparam logic [1:0] ADDR_STATUS = 2'd3;

    localparam int CTRL_ENABLE_BIT = 0;
    localparam int CTRL_LEN_LSB    = 8;
    localparam int CTRL_LEN_MSB    = 11;

    localparam int STATUS_DONE_BIT = 1;

    localparam int CHAR_IDX_LSB = 0;
    localparam int CHAR_IDX_MSB = 3;
    localparam int CHAR_PAT_LSB = 8;
    localparam int CHAR_PAT_MSB = 14;

    localparam int RATE_W      = 24;
    localparam int POS_W       = 5;
    localparam int NUM_ENTRIES = 16;
    localparam int NUM_DIGITS  = 6;

    typedef logic [6:0] seg_t;

    localparam seg_t SEG_BLANK = 7'h00;
    localparam seg_t HEX_OFF   = 7'h7F;

    typedef seg_t [NUM_ENTRIES-1:0] msg_buf_t;

    // Packed so that a CTRL write maps straight onto {b11:8, b3:0}.
    typedef struct packed {
        logic [3:0] len_m1;
        logic       irq_en;
        logic       oneshot;
        logic       blink_en;
        logic       enable;
    } ctrl_t;

    // Virtual stream lookup: entries past the message length read as blank.
    function automatic seg_t stream_seg(input msg_buf_t msg,
                                        input logic [POS_W-1:0] idx,
                                        input logic [POS_W-1:0] len);
        if (idx < len) begin
            return msg[idx[3:0]];
        end
        return SEG_BLANK;
    endfunction

endpackage

// File: rtl/hex_tick_gen.sv
// Reloadable down-counting prescaler producing a one-cycle step pulse
// every reload+1 enabled clocks. A restart reloads without stepping.
module hex_tick_gen #(
    parameter int             W           = 24,
    parameter logic [W-1:0]   RESET_COUNT = '0
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         enable,
    input  logic         restart,
    input  logic [W-1:0] reload,
    output logic         step
);

    logic [W-1:0] count;

    assign step = enable & ~restart & (count == '0);

    // Count down while enabled, reload on expiry or restart, hold when disabled.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            count <= RESET_COUNT;
        end else if (restart) begin
            count <= reload;
        end else if (enable) begin
            if (count == '0) begin
                count <= reload;
            end else begin
                count <= count - 1'b1;
            end
        end
    end

endmodule

// File: rtl/hex_scroll_ctrl.sv
// Avalon-MM slave that scrolls a 16-entry segment message leftward across
// six active-low HEX displays, with circular/one-shot modes and blinking.
module hex_scroll_ctrl
    import hex_scroll_pkg::*;
#(
    parameter int RATE_RESET = 12499999,
    parameter int BLINK_LOG2 = 24
) (
    input  logic        clk_clk,
    input  logic        reset_reset_n,
    input  logic [1:0]  avs_address,
    input  logic        avs_write,
    input  logic [31:0] avs_writedata,
    input  logic        avs_read,
    output logic [31:0] avs_readdata,
    output logic        irq,
    output logic [6:0]  hex0,
    output logic [6:0]  hex1,
    output logic [6:0]  hex2,
    output logic [6:0]  hex3,
    output logic [6:0]  hex4,
    output logic [6:0]  hex5
);

    localparam logic [RATE_W-1:0] RATE_INIT = RATE_W'(RATE_RESET);

    ctrl_t              ctrl, ctrl_next;
    logic [RATE_W-1:0]  rate;
    msg_buf_t           msg_buf;
    logic [POS_W-1:0]   pos, pos_next;
    logic               done, done_next;
    logic [BLINK_LOG2:0] blink_cnt;
    logic               blink_phase;
    seg_t               hex_q [NUM_DIGITS];
    seg_t               hex_d [NUM_DIGITS];
    logic               ctrl_wr, rate_wr, char_wr, status_wr;
    logic               restart, step, busy;
    logic [POS_W-1:0]   len, new_len;
    logic [31:0]        rd_value;
    logic               unused_wdata;

    assign unused_wdata = &{1'b0, avs_writedata[31:24]};

    assign ctrl_wr   = avs_write && (avs_address == ADDR_CTRL);
    assign rate_wr   = avs_write && (avs_address == ADDR_RATE);
    assign char_wr   = avs_write && (avs_address == ADDR_CHAR);
    assign status_wr = avs_write && (avs_address == ADDR_STATUS);
    assign restart   = ctrl_wr && avs_writedata[CTRL_ENABLE_BIT];

    assign len     = {1'b0, ctrl.len_m1} + 5'd1;
    assign new_len = {1'b0, avs_writedata[CTRL_LEN_MSB:CTRL_LEN_LSB]} + 5'd1;

    assign busy        = ctrl.enable & ~done;
    assign blink_phase = blink_cnt[BLINK_LOG2];
    assign irq         = done & ctrl.irq_en;

    hex_tick_gen #(
        .W           (RATE_W),
        .RESET_COUNT (RATE_INIT)
    ) u_tick (
        .clk     (clk_clk),
        .rst_n   (reset_reset_n),
        .enable  (ctrl.enable),
        .restart (restart),
        .reload  (rate),
        .step    (step)
    );

    // Next control/position/done: a CTRL write overrides a coincident step,
    // and a step that sets done overrides a coincident done clear.
    always_comb begin
        ctrl_next = ctrl;
        pos_next  = pos;
        done_next = done;
        if (status_wr && avs_writedata[STATUS_DONE_BIT]) begin
            done_next = 1'b0;
        end
        if (ctrl_wr) begin
            ctrl_next = ctrl_t'({avs_writedata[CTRL_LEN_MSB:CTRL_LEN_LSB], avs_writedata[3:0]});
            if (avs_writedata[CTRL_ENABLE_BIT]) begin
                pos_next  = '0;
                done_next = 1'b0;
            end else if (pos > new_len) begin
                pos_next = new_len;
            end
        end else if (step) begin
            if (ctrl.oneshot) begin
                if (pos < len) begin
                    pos_next = pos + 5'd1;
                    if (pos + 5'd1 == len) begin
                        done_next        = 1'b1;
                        ctrl_next.enable = 1'b0;
                    end
                end
            end else if (pos >= len - 5'd1) begin
                pos_next = '0;
            end else begin
                pos_next = pos + 5'd1;
            end
        end
    end

    // Control, position and done state registers.
    always_ff @(posedge clk_clk) begin
        if (!reset_reset_n) begin
            ctrl <= '0;
            pos  <= '0;
            done <= 1'b0;
        end else begin
            ctrl <= ctrl_next;
            pos  <= pos_next;
            done <= done_next;
        end
    end

    // RATE register and message buffer writes.
    always_ff @(posedge clk_clk) begin
        if (!reset_reset_n) begin
            rate    <= RATE_INIT;
            msg_buf <= '0;
        end else begin
            if (rate_wr) begin
                rate <= avs_writedata[RATE_W-1:0];
            end
            if (char_wr) begin
                msg_buf[avs_writedata[CHAR_IDX_MSB:CHAR_IDX_LSB]] <= avs_writedata[CHAR_PAT_MSB:CHAR_PAT_LSB];
            end
        end
    end

    // Free-running blink counter; its top bit is the blink phase.
    always_ff @(posedge clk_clk) begin
        if (!reset_reset_n) begin
            blink_cnt <= '0;
        end else begin
            blink_cnt <= blink_cnt + 1'b1;
        end
    end

    // Digit k (k=0 is HEX5) shows stream[pos+k], inverted for active-low drive.
    always_comb begin
        for (int k = 0; k < NUM_DIGITS; k++) begin
            if (ctrl.blink_en && blink_phase) begin
                hex_d[k] = HEX_OFF;
            end else begin
                hex_d[k] = ~stream_seg(msg_buf, pos + POS_W'(k), len);
            end
        end
    end

    // Registered segment outputs.
    always_ff @(posedge clk_clk) begin
        if (!reset_reset_n) begin
            for (int k = 0; k < NUM_DIGITS; k++) begin
                hex_q[k] <= HEX_OFF;
            end
        end else begin
            for (int k = 0; k < NUM_DIGITS; k++) begin
                hex_q[k] <= hex_d[k];
            end
        end
    end

    assign hex5 = hex_q[0];
    assign hex4 = hex_q[1];
    assign hex3 = hex_q[2];
    assign hex2 = hex_q[3];
    assign hex1 = hex_q[4];
    assign hex0 = hex_q[5];

    // Read mux for the addressed register.
    always_comb begin
        rd_value = '0;
        case (avs_address)
            ADDR_CTRL:   rd_value = {20'd0, ctrl.len_m1, 4'd0, ctrl.irq_en, ctrl.oneshot, ctrl.blink_en, ctrl.enable};
            ADDR_RATE:   rd_value = {8'd0, rate};
            ADDR_STATUS: rd_value = {23'd0, pos, 2'd0, done, busy};
            default:     rd_value = '0;
        endcase
    end

    // Read data captured one clock after the read strobe, held otherwise.
    always_ff @(posedge clk_clk) begin
        if (!reset_reset_n) begin
            avs_readdata <= '0;
        end else if (avs_read) begin
            avs_readdata <= rd_value;
        end
    end

endmodule

// File: tb/tb_hex_scroll_ctrl.sv
// Self-checking bench for hex_scroll_ctrl: directed steps plus randomized
// traffic compared each clock against a behavioural model of the controller.
module tb_hex_scroll_ctrl;

    logic        clk_clk = 1'b0;
    logic        reset_reset_n = 1'b0;
    logic [1:0]  avs_address = '0;
    logic        avs_write = 1'b0;
    logic [31:0] avs_writedata = '0;
    logic        avs_read = 1'b0;
    logic [31:0] avs_readdata;
    logic        irq;
    logic [6:0]  hex0, hex1, hex2, hex3, hex4, hex5;

    int checks = 0;
    int errors = 0;

    hex_scroll_ctrl #(
        .RATE_RESET (12499999),
        .BLINK_LOG2 (4)
    ) dut (
        .clk_clk       (clk_clk),
        .reset_reset_n (reset_reset_n),
        .avs_address   (avs_address),
        .avs_write     (avs_write),
        .avs_writedata (avs_writedata),
        .avs_read      (avs_read),
        .avs_readdata  (avs_readdata),
        .irq           (irq),
        .hex0          (hex0),
        .hex1          (hex1),
        .hex2          (hex2),
        .hex3          (hex3),
        .hex4          (hex4),
        .hex5          (hex5)
    );

    always #5 clk_clk = ~clk_clk;

    // Behavioural model state
    bit          m_en, m_blink, m_one, m_irqen, m_done;
    int          m_lenm1, m_rate, m_pos, m_count, m_cyc;
    int          m_buf [16];
    logic [31:0] m_rdata;
    logic [6:0]  m_hex [6];

    function automatic logic [6:0] hexvec(input int d);
        case (d)
            0: return hex0;
            1: return hex1;
            2: return hex2;
            3: return hex3;
            4: return hex4;
            default: return hex5;
        endcase
    endfunction

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("[TB] FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_en = 0; m_blink = 0; m_one = 0; m_irqen = 0; m_done = 0;
        m_lenm1 = 0; m_rate = 12499999; m_count = 12499999; m_pos = 0; m_cyc = 0;
        m_rdata = '0;
        for (int i = 0; i < 16; i++) m_buf[i] = 0;
        for (int d = 0; d < 6; d++) m_hex[d] = 7'h7F;
    endtask

    // Advance the model across one clock edge using the inputs now on the bus.
    task automatic model_edge();
        int len, idx, seg, nlen, n_pos;
        bit cwr, restart, step, n_done;
        if (!reset_reset_n) begin
            model_reset();
            return;
        end
        len = m_lenm1 + 1;
        for (int d = 0; d < 6; d++) begin
            idx = m_pos + (5 - d);
            seg = (idx < len) ? m_buf[idx] : 0;
            m_hex[d] = (m_blink && ((m_cyc / 16) % 2 == 1)) ? 7'h7F : (7'h7F ^ 7'(seg));
        end
        if (avs_read) begin
            case (avs_address)
                2'd0: m_rdata = 32'(m_lenm1 * 256 + m_irqen * 8 + m_one * 4 + m_blink * 2 + m_en);
                2'd1: m_rdata = 32'(m_rate);
                2'd2: m_rdata = 32'd0;
                default: m_rdata = 32'(m_pos * 16 + m_done * 2 + (m_en && !m_done));
            endcase
        end
        cwr     = avs_write && avs_address == 2'd0;
        restart = cwr && avs_writedata[0];
        step    = m_en && m_count == 0 && !restart;
        if (restart) m_count = m_rate;
        else if (m_en) m_count = (m_count == 0) ? m_rate : m_count - 1;
        n_pos = m_pos;
        n_done = m_done;
        if (avs_write && avs_address == 2'd3 && avs_writedata[1]) n_done = 0;
        if (avs_write && avs_address == 2'd2) m_buf[avs_writedata[3:0]] = int'(avs_writedata[14:8]);
        if (avs_write && avs_address == 2'd1) m_rate = int'(avs_writedata[23:0]);
        if (cwr) begin
            nlen    = int'(avs_writedata[11:8]) + 1;
            m_en    = avs_writedata[0];
            m_blink = avs_writedata[1];
            m_one   = avs_writedata[2];
            m_irqen = avs_writedata[3];
            m_lenm1 = int'(avs_writedata[11:8]);
            if (avs_writedata[0]) begin
                n_pos = 0;
                n_done = 0;
            end else if (m_pos > nlen) begin
                n_pos = nlen;
            end
        end else if (step) begin
            if (m_one) begin
                if (m_pos < len) begin
                    n_pos = m_pos + 1;
                    if (n_pos == len) begin
                        n_done = 1;
                        m_en = 0;
                    end
                end
            end else begin
                n_pos = (m_pos == len - 1) ? 0 : m_pos + 1;
            end
        end
        m_pos = n_pos;
        m_done = n_done;
        m_cyc++;
    endtask

    // One clock with the given bus transaction, then compare all outputs.
    task automatic applyStimulus(input bit wr, input bit rd, input logic [1:0] addr, input logic [31:0] data);
        avs_write = wr;
        avs_read = rd;
        avs_address = addr;
        avs_writedata = data;
        model_edge();
        @(posedge clk_clk);
        #1;
        avs_write = 1'b0;
        avs_read = 1'b0;
        for (int d = 0; d < 6; d++) checkOutput($sformatf("hex%0d", d), hexvec(d), m_hex[d]);
        checkOutput("irq", irq, m_done & m_irqen);
        checkOutput("rdata", avs_readdata, m_rdata);
    endtask

    task automatic write_reg(input logic [1:0] addr, input logic [31:0] data);
        applyStimulus(1'b1, 1'b0, addr, data);
    endtask

    task automatic read_reg(input logic [1:0] addr);
        applyStimulus(1'b0, 1'b1, addr, 32'd0);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) applyStimulus(1'b0, 1'b0, 2'd0, 32'd0);
    endtask

    initial begin
        int n, p, cur, exp_p, last_change, t, pat, lm1, sel;
        logic [6:0] pats [16];
        logic [6:0] exp_h;

        $display("[TB] start");
        // Reset and register defaults
        idle(2);
        reset_reset_n = 1'b1;
        for (int d = 0; d < 6; d++) checkOutput("rst_hex", hexvec(d), 7'h7F);
        checkOutput("rst_irq", irq, 0);
        read_reg(2'd0); checkOutput("rst_ctrl", avs_readdata, 32'd0);
        read_reg(2'd1); checkOutput("rst_rate", avs_readdata, 32'd12499999);
        read_reg(2'd3); checkOutput("rst_status", avs_readdata, 32'd0);

        // Static display
        write_reg(2'd2, 32'h0600);
        write_reg(2'd2, 32'h5B01);
        write_reg(2'd2, 32'h4F02);
        write_reg(2'd2, 32'h6603);
        write_reg(2'd2, 32'h6D04);
        write_reg(2'd2, 32'h7D05);
        write_reg(2'd0, 32'h0500);
        idle(1);
        checkOutput("static_hex5", hex5, 7'h79);
        checkOutput("static_hex4", hex4, 7'h24);
        checkOutput("static_hex3", hex3, 7'h30);
        checkOutput("static_hex2", hex2, 7'h19);
        checkOutput("static_hex1", hex1, 7'h12);
        checkOutput("static_hex0", hex0, 7'h02);

        // Circular scroll, step every 4 clocks through 0..7
        pats[6] = 7'($urandom_range(1, 127));
        pats[7] = 7'($urandom_range(1, 127));
        write_reg(2'd2, {17'd0, pats[6], 8'd6});
        write_reg(2'd2, {17'd0, pats[7], 8'd7});
        write_reg(2'd1, 32'd3);
        write_reg(2'd0, 32'h0701);
        cur = 0; exp_p = 0; last_change = -1;
        for (int i = 0; i < 40; i++) begin
            read_reg(2'd3);
            p = int'(avs_readdata[8:4]);
            if (p != cur) begin
                exp_p = (exp_p + 1) % 8;
                checkOutput("circ_pos", p, exp_p);
                if (last_change >= 0) checkOutput("circ_gap", i - last_change, 4);
                last_change = i;
                cur = p;
            end
        end
        n = 0;
        while (m_pos != 7 && n < 40) begin idle(1); n++; end
        if (n >= 40) begin
            checks++; errors++;
            $error("[TB] FAIL circ_wait observed=timeout expected=pos7");
        end
        idle(1);
        checkOutput("circ7_hex5", hex5, 7'h7F ^ pats[7]);
        checkOutput("circ7_hex4", hex4, 7'h7F);
        checkOutput("circ7_hex0", hex0, 7'h7F);

        // One-shot with interrupt
        write_reg(2'd1, 32'd0);
        write_reg(2'd0, 32'h020D);
        idle(4);
        checkOutput("os_irq", irq, 1);
        for (int d = 0; d < 6; d++) checkOutput("os_hex", hexvec(d), 7'h7F);
        read_reg(2'd3); checkOutput("os_status", avs_readdata, 32'h32);
        read_reg(2'd0); checkOutput("os_ctrl", avs_readdata, 32'h20C);
        write_reg(2'd3, 32'h2);
        checkOutput("os_irq_clr", irq, 0);

        // Pause, clamp, resume
        for (int i = 0; i < 16; i++) begin
            pats[i] = 7'($urandom_range(0, 127));
            write_reg(2'd2, {17'd0, pats[i], 4'd0, 4'(i)});
        end
        write_reg(2'd1, 32'd2);
        write_reg(2'd0, 32'h0901);
        n = 0;
        while (m_pos != 6 && n < 200) begin idle(1); n++; end
        if (n >= 200) begin
            checks++; errors++;
            $error("[TB] FAIL pause_wait observed=timeout expected=pos6");
        end
        write_reg(2'd0, 32'h0300);
        read_reg(2'd3); checkOutput("clamp_pos", avs_readdata[8:4], 4);
        idle(5);
        read_reg(2'd3); checkOutput("clamp_hold", avs_readdata, 32'h40);
        write_reg(2'd0, 32'h0301);
        read_reg(2'd3); checkOutput("resume_status", avs_readdata, 32'h01);

        // Blink with random traffic while scrolling
        write_reg(2'd1, 32'd5);
        write_reg(2'd0, 32'h0F03);
        for (int i = 0; i < 100; i++) begin
            sel = $urandom_range(0, 3);
            case (sel)
                0: write_reg(2'd2, 32'($urandom_range(0, 127) * 256 + $urandom_range(0, 15)));
                1: read_reg(2'($urandom_range(0, 3)));
                default: idle(1);
            endcase
        end
        // CHAR write landing on the same clock as a step
        n = 0;
        while (!(m_en && m_count == 0) && n < 20) begin idle(1); n++; end
        if (n >= 20) begin
            checks++; errors++;
            $error("[TB] FAIL step_wait observed=timeout expected=step");
        end
        t = (m_pos >= 15) ? 0 : m_pos + 1;
        pat = $urandom_range(1, 127);
        write_reg(2'd2, 32'(pat * 256 + t));
        idle(1);
        exp_h = (((m_cyc - 1) / 16) % 2 == 1) ? 7'h7F : (7'h7F ^ 7'(pat));
        checkOutput("coinc_hex5", hex5, exp_h);

        // Randomized configurations
        for (int r = 0; r < 4; r++) begin
            lm1 = $urandom_range(0, 15);
            write_reg(2'd1, 32'($urandom_range(0, 3)));
            write_reg(2'd0, 32'(lm1 * 256 + ($urandom_range(0, 7) * 2) + 1));
            for (int i = 0; i < 50; i++) begin
                sel = $urandom_range(0, 6);
                case (sel)
                    0: write_reg(2'd2, 32'($urandom_range(0, 127) * 256 + $urandom_range(0, 15)));
                    1: read_reg(2'($urandom_range(0, 3)));
                    2: write_reg(2'd3, 32'h2);
                    3: write_reg(2'd1, 32'($urandom_range(0, 3)));
                    default: idle(1);
                endcase
            end
        end

        // Reset in the middle of a scroll
        write_reg(2'd1, 32'd1);
        write_reg(2'd0, 32'h0F01);
        idle(7);
        reset_reset_n = 1'b0;
        idle(1);
        reset_reset_n = 1'b1;
        for (int d = 0; d < 6; d++) checkOutput("mid_rst_hex", hexvec(d), 7'h7F);
        checkOutput("mid_rst_rdata", avs_readdata, 32'd0);
        read_reg(2'd0); checkOutput("mid_rst_ctrl", avs_readdata, 32'd0);
        read_reg(2'd1); checkOutput("mid_rst_rate", avs_readdata, 32'd12499999);
        read_reg(2'd3); checkOutput("mid_rst_status", avs_readdata, 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/hex_scroll_ctrl.md
Name: hex_scroll_ctrl

Overview:
- Avalon-MM slave controller that owns the six HEX displays (HEX5 leftmost, HEX0 rightmost).
- Holds a 16-entry segment-pattern message buffer and scrolls it leftward across the displays at a programmable rate.
- Scrolling is either circular or one-shot; one-shot completion raises an interrupt. Optional blinking.
- Sits in soc_system, driving the six 7-bit hex conduits (active-low segments); programmed by the HPS over the lightweight bridge.

Parameters:
- RATE_RESET, 12499999, reset value of the RATE register; a step occurs every RATE+1 clocks (0.25 s at 50 MHz).
- BLINK_LOG2, 24, blink half-period is 2^BLINK_LOG2 clocks.

Ports:
- clk_clk  in  1  system clock
- reset_reset_n  in  1  synchronous, active-low reset
- avs_address  in  2  word address
- avs_write  in  1  write strobe
- avs_writedata  in  32  write data
- avs_read  in  1  read strobe
- avs_readdata  out  32  read data, latency 1
- irq  out  1  level interrupt = DONE & CTRL.irq_en
- hex0 .. hex5  out  7 each  segment drives, active-low, bit0 = segment a

Behaviour:
- Register map (word address):
  - 0 CTRL (R/W): b0 enable, b1 blink_en, b2 oneshot, b3 irq_en, b11:8 len_m1 (message length = len_m1+1, range 1..16).
  - 1 RATE (R/W): b23:0; upper bits read 0.
  - 2 CHAR (write-only, reads 0): b3:0 index, b14:8 pattern. Pattern is active-high segments.
  - 3 STATUS (R): b0 busy, b1 done, b8:4 pos. Writing 1 to b1 clears done.
- Reset values:
  - CTRL=0, RATE=RATE_RESET, all buffer entries 0 (blank), pos=0, done=0.
  - Prescaler count = RATE_RESET, blink phase=0.
  - hex0..hex5 = 7'h7F, avs_readdata=0, irq=0.
- Virtual stream: stream[i] = buf[i] for i<len, blank (0) for i>=len, for i in 0..21. Digit k (HEX5=k0 .. HEX0=k5) shows stream[pos+k]. pos is 5 bits.
- Prescaler:
  - Down-counter; when enable=1 and count==0, issue a step and reload RATE. Otherwise decrement while enabled.
  - Holds its value while enable=0.
- Step rules:
  - Circular mode: pos = (pos==len-1) ? 0 : pos+1.
  - One-shot mode: if pos<len then pos+1. When pos becomes len (all digits blank), set done and clear enable. No further steps.
- busy = enable & ~done.
- Any CTRL write with b0=1 restarts: pos=0, done=0, count=RATE (new RATE if written the same cycle is not possible, since it is a separate address; current RATE is used).
- CTRL write with b0=0 pauses: pos and count are frozen and the display holds.
- Writing len_m1 while paused: pos is clamped to min(pos, new len) on the same write.
- Outputs registered: hex = ~pattern, updated 1 clock after any change to pos, buf, len, or blink phase.
- Blink:
  - A free-running counter toggles phase every 2^BLINK_LOG2 clocks.
  - If blink_en & phase, all hex outputs are 7'h7F. The buffer and pos are unaffected.
- Simultaneous events:
  - CHAR write in the same cycle as a step: both take effect; the display reflects the new pattern and new pos on the next clock.
  - Done-W1C in the same cycle as done being set: set wins.
- Reads have 1-cycle latency; avs_readdata holds its last value when no read is active.
- Reset asserted mid-scroll returns every state element to its reset value on that clock edge.

Decomposition:
- Package hex_scroll_pkg:
  - register address constants and CTRL/STATUS bit-field positions
  - SEG_BLANK=7'h00 and HEX_OFF=7'h7F
  - typedef seg_t (7-bit) and typedef for the 16-entry buffer array
- Sub-module hex_tick_gen: reloadable prescaler with enable, restart, and a 1-cycle step pulse output.
- Everything else (register file, buffer, pos FSM, blink, output mux) lives in hex_scroll_ctrl.

Test Plan:
- Reset, then read all registers:
  - CTRL=0, RATE=12499999, STATUS=0, hex0..5=7'h7F, irq=0.
- Static display:
  - Stimulus: CHAR idx0..5 = 0x06,0x5B,0x4F,0x66,0x6D,0x7D; CTRL len_m1=5, enable=0.
  - Required: hex5..hex0 = 0x79,0x24,0x30,0x19,0x12,0x02.
- Circular scroll:
  - Stimulus: RATE=3, len_m1=7, CTRL enable=1.
  - Required: pos steps every 4 clocks through 0..7 then back to 0. At pos=7, HEX5 shows ~buf[7] and HEX4..HEX0 show 7'h7F.
- One-shot with interrupt:
  - Stimulus: RATE=0, len_m1=2, oneshot=1, irq_en=1, enable=1.
  - Required: after 3 steps, pos=3, done=1, irq=1, CTRL.enable=0, all hex=7'h7F. Writing STATUS b1=1 drops irq the next clock.
- Pause, resume, clamp:
  - Stimulus: pause at pos=6 and write len_m1=3 with enable=0.
  - Required: pos reads 4. Re-enabling restarts at pos=0.
- Blink with BLINK_LOG2=4:
  - Required: outputs alternate between the pattern and 7'h7F every 16 clocks while pos keeps advancing.
  - A CHAR write coincident with a step updates the display on the next clock.
